// File: rtl/apb2axi_axi_wr_master.sv
// Single-beat AXI write master fed from the APB-side request FIFO.
// Keeps at most one write outstanding: it issues AW and W together, waits for
// the B response, then presents a completion that must be taken with rsp_ready_i
// before the next request is accepted.
module apb2axi_axi_wr_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,

    // Request side
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_data_i,
    input  logic [DATA_W/8-1:0] req_strb_i,
    input  logic [ID_W-1:0]     req_id_i,

    // AXI write address channel
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic [ID_W-1:0]     awid_o,
    output logic [7:0]          awlen_o,
    output logic [2:0]          awsize_o,
    output logic [1:0]          awburst_o,

    // AXI write data channel
    output logic                wvalid_o,
    input  logic                wready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,

    // AXI write response channel
    input  logic                bvalid_i,
    output logic                bready_o,
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,

    // Completion toward the APB side
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic [1:0]          rsp_resp_o,
    output logic                rsp_id_err_o
);

    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam logic [2:0]  AW_SIZE = 3'($clog2(STRB_W));
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAddrData,
        StWaitB,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                aw_pend_q, aw_pend_d;
    logic                w_pend_q, w_pend_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                rsp_id_err_q, rsp_id_err_d;

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            id_q         <= '0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            rsp_resp_q   <= 2'b00;
            rsp_id_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            id_q         <= id_d;
            aw_pend_q    <= aw_pend_d;
            w_pend_q     <= w_pend_d;
            rsp_resp_q   <= rsp_resp_d;
            rsp_id_err_q <= rsp_id_err_d;
        end
    end

    // Next-state logic: capture request, retire AW/W independently, take B, hand off.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        id_d         = id_q;
        aw_pend_d    = aw_pend_q;
        w_pend_d     = w_pend_q;
        rsp_resp_d   = rsp_resp_q;
        rsp_id_err_d = rsp_id_err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready_o) begin
                    addr_d    = req_addr_i;
                    data_d    = req_data_i;
                    strb_d    = req_strb_i;
                    id_d      = req_id_i;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    state_d   = StAddrData;
                end
            end
            StAddrData: begin
                if (aw_pend_q && awready_i) begin
                    aw_pend_d = 1'b0;
                end
                if (w_pend_q && wready_i) begin
                    w_pend_d = 1'b0;
                end
                // Both channels done (either order, or together) -> wait for B.
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (bvalid_i) begin
                    rsp_id_err_d = (bid_i != id_q);
                    rsp_resp_d   = (bid_i != id_q) ? RESP_SLVERR : bresp_i;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode; valids come straight from state/pending flags.
    always_comb begin
        req_ready_o  = (state_q == StIdle) && !rst;
        awvalid_o    = aw_pend_q;
        awaddr_o     = addr_q;
        awid_o       = id_q;
        awlen_o      = 8'd0;
        awsize_o     = AW_SIZE;
        awburst_o    = 2'b01;
        wvalid_o     = w_pend_q;
        wdata_o      = data_q;
        wstrb_o      = strb_q;
        wlast_o      = w_pend_q;
        bready_o     = (state_q == StWaitB);
        rsp_valid_o  = (state_q == StResp);
        rsp_id_o     = id_q;
        rsp_resp_o   = rsp_resp_q;
        rsp_id_err_o = rsp_id_err_q;
    end

endmodule
